// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: branch opcodes, 2-bit counter encodings
// and the saturating counter step used by the branch history table.
package mips_pkg;

  localparam logic [5:0] OPC_BEQ = 6'h04;
  localparam logic [5:0] OPC_BNE = 6'h05;

  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not taken
    WNT = 2'b01,  // weakly not taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } cnt_e;

  // True for the conditional branches the predictor handles.
  function automatic logic is_branch(input logic [5:0] opc);
    return (opc == OPC_BEQ) || (opc == OPC_BNE);
  endfunction

  // One saturating step of a 2-bit counter towards the observed outcome.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && (cnt != ST)) begin
      nxt = cnt + 2'd1;
    end else if (!taken && (cnt != SNT)) begin
      nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: 2^BHT_IDX_W two-bit saturating counters with an
// asynchronous read port (IF lookup) and a clocked update port (ID resolution).
// A lookup of the entry being updated returns the pre-update value.
module bht_2bit
  import mips_pkg::*;
#(
  parameter int         BHT_IDX_W = 4,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic [1:0]           rd_cnt,
  input  logic                 upd_en,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  localparam int ENTRIES = 1 << BHT_IDX_W;

  logic [1:0] cnt_q [ENTRIES];

  // Counter array: reset every entry, saturating step on resolution.
  // NOTE: the table is small and must start at a known predictor state, so it
  // is built from resettable flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
    end else if (upd_en) begin
      cnt_q[upd_idx] <= cnt_next(cnt_q[upd_idx], upd_taken);
    end
  end

  assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// IF-stage dynamic branch predictor with ID-stage resolution and recovery.
// Predicts beq/bne from a PC-indexed 2-bit counter table, shadows the
// prediction alongside IF/ID, and on a mispredict flushes IF/ID and supplies
// the corrected fetch PC in the same cycle.
// Optional statistics counters are built when BRPRED_STATS_EN is defined;
// otherwise br_count and mispred_count are tied to zero.
module branch_predict_unit
  import mips_pkg::*;
#(
  parameter int         BHT_IDX_W = 4,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  input  logic [31:0] inst_if,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        br_resolve_id,
  input  logic        br_taken_id,
  output logic        pred_taken_if,
  output logic [31:0] pred_pc_if,
  output logic        flush_if_id,
  output logic [31:0] redirect_pc,
  output logic [15:0] br_count,
  output logic [15:0] mispred_count
);

  // Prediction context for the instruction currently held in IF/ID.
  typedef struct packed {
    logic                 valid;
    logic                 pred_taken;
    logic [BHT_IDX_W-1:0] idx;
    logic [31:0]          pc_plus4;
    logic [31:0]          target;
  } shadow_t;

  logic                 is_branch_if;
  logic [BHT_IDX_W-1:0] idx_if;
  logic [31:0]          pc_plus4_if;
  logic [31:0]          target_if;
  logic [1:0]           cnt_if;
  shadow_t              shadow_q;
  logic                 res;
  logic                 mispredict;

  // Register fields and operands the predictor never looks at.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst_if[25:16];

  // IF lookup: decode, target computation and prediction are purely combinational.
  assign is_branch_if  = is_branch(inst_if[31:26]);
  assign idx_if        = pc_if[BHT_IDX_W+1:2];
  assign pc_plus4_if   = pc_if + 32'd4;
  assign target_if     = pc_plus4_if + {{14{inst_if[15]}}, inst_if[15:0], 2'b00};
  assign pred_taken_if = is_branch_if & cnt_if[1];
  assign pred_pc_if    = pred_taken_if ? target_if : pc_plus4_if;

  bht_2bit #(
    .BHT_IDX_W (BHT_IDX_W),
    .CNT_INIT  (CNT_INIT)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (idx_if),
    .rd_cnt    (cnt_if),
    .upd_en    (res),
    .upd_idx   (shadow_q.idx),
    .upd_taken (br_taken_id)
  );

  // ID resolution: act only in non-stalled cycles so a held branch resolves once.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    res         = 1'b0;
    mispredict  = 1'b0;
    flush_if_id = 1'b0;
    redirect_pc = 32'h0;
    res         = br_resolve_id & shadow_q.valid & pc_write & if_id_write;
    mispredict  = res & (br_taken_id != shadow_q.pred_taken);
    if (mispredict) begin
      flush_if_id = 1'b1;
      redirect_pc = br_taken_id ? shadow_q.target : shadow_q.pc_plus4;
    end
  end

  // Shadow register tracks IF/ID: bubble on flush, hold on stall, else load IF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (mispredict) begin
      shadow_q.valid <= 1'b0;
    end else if (if_id_write) begin
      shadow_q <= '{valid:      is_branch_if,
                    pred_taken: pred_taken_if,
                    idx:        idx_if,
                    pc_plus4:   pc_plus4_if,
                    target:     target_if};
    end
  end

`ifdef BRPRED_STATS_EN
  logic [15:0] br_count_q;
  logic [15:0] mispred_count_q;

  // Saturating event counters for resolved branches and mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q      <= 16'h0;
      mispred_count_q <= 16'h0;
    end else begin
      if (res && (br_count_q != 16'hFFFF)) begin
        br_count_q <= br_count_q + 16'd1;
      end
      if (mispredict && (mispred_count_q != 16'hFFFF)) begin
        mispred_count_q <= mispred_count_q + 16'd1;
      end
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;
`else
  assign br_count      = 16'h0;
  assign mispred_count = 16'h0;
`endif

endmodule
